lifo_stack_register: RTL and testbench

- Parametrised depth-N register stack (LIFO) with load-style push/pop controls.
- Next generation of the single load/reset register.
- Serves as the A09 hardware return-address stack and interrupt-context stack.
- Sits beside the PC/IR datapath; the control matrix drives push/pop, and top-of-stack feeds the PC mux.

---
 rtl/lifo_stack_register_pkg.sv | 22 ++
 rtl/lifo_stack_register_if.sv | 29 ++
 rtl/lifo_stack_register_stack_mem.sv | 26 ++
 rtl/lifo_stack_register.sv | 117 +++++++++++
 tb/tb_lifo_stack_register.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lifo_stack_register_pkg.sv
// Shared control encodings and defaults for the A09 register stack.
// Controls are active-low, so ASSERTED is the low level.
package lifo_stack_register_pkg;

  localparam logic ASSERTED   = 1'b0;
  localparam logic DEASSERTED = 1'b1;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_DEPTH      = 8;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic push_n, input logic pop_n);
    return stack_op_e'({push_n == ASSERTED, pop_n == ASSERTED});
  endfunction

endpackage

// File: rtl/lifo_stack_register_if.sv
// Control/data bundle between the A09 control matrix and the register stack.
// master drives push/pop/clear/data; slave returns top-of-stack, count and flags.
interface lifo_stack_register_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic                  push_ni;
  logic                  pop_ni;
  logic                  clr_err_ni;
  logic [DATA_WIDTH-1:0] data_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic [ADDR_WIDTH:0]   count_o;
  logic                  empty_o;
  logic                  full_o;
  logic                  overflow_o;
  logic                  underflow_o;

  modport master (
    output push_ni, pop_ni, clr_err_ni, data_i,
    input  data_o, count_o, empty_o, full_o, overflow_o, underflow_o
  );

  modport slave (
    input  push_ni, pop_ni, clr_err_ni, data_i,
    output data_o, count_o, empty_o, full_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/lifo_stack_register_stack_mem.sv
// DEPTH x DATA_WIDTH storage, written on the falling edge, read combinationally.
// Kept on its own so it can be swapped for an iCE40 block RAM later.
module lifo_stack_register_stack_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(negedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack_register.sv
// Depth-N LIFO register stack with active-low push/pop; state updates on the falling edge.
// Top-of-stack, count and sticky flags are valid right after the edge; overflow is blocked, never wrapped.
module lifo_stack_register
  import lifo_stack_register_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input logic                  clk_i,
  input logic                  reset_ni,
  lifo_stack_register_if.slave bus
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic      is_empty;
  logic      is_full;
  logic      clr_err;
  stack_op_e op;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_COUNT);
  assign clr_err  = (bus.clr_err_ni == ASSERTED);
  assign op       = decode_op(bus.push_ni, bus.pop_ni);

  // Low index bits stay correct at count==DEPTH because the modulo wrap lands on DEPTH-2.
  assign mem_raddr = count_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(2);

  lifo_stack_register_stack_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_stack_mem (
    .clk_i (clk_i),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (bus.data_i),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_comb begin
    count_d   = count_q;
    data_d    = data_q;
    ovf_d     = clr_err ? 1'b0 : ovf_q;
    unf_d     = clr_err ? 1'b0 : unf_q;
    mem_we    = 1'b0;
    mem_waddr = count_q[ADDR_WIDTH-1:0];

    unique case (op)
      OP_PUSH: begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          mem_we  = 1'b1;
          count_d = count_q + 1'b1;
          data_d  = bus.data_i;
        end
      end
      OP_POP: begin
        if (is_empty) begin
          unf_d = 1'b1;
        end else if (count_q == (ADDR_WIDTH+1)'(1)) begin
          count_d = '0;
          data_d  = '0;
        end else begin
          count_d = count_q - 1'b1;
          data_d  = mem_rdata;
        end
      end
      OP_REPLACE: begin
        // An empty stack has no top to replace, so this degrades to a plain push.
        mem_we = 1'b1;
        data_d = bus.data_i;
        if (is_empty) begin
          count_d = (ADDR_WIDTH+1)'(1);
        end else begin
          mem_waddr = count_q[ADDR_WIDTH-1:0] - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(negedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.data_o      = data_q;
  assign bus.count_o     = count_q;
  assign bus.empty_o     = is_empty;
  assign bus.full_o      = is_full;
  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = unf_q;

endmodule

// File: tb/tb_lifo_stack_register.sv
// Bench for lifo_stack_register: directed scenarios plus a randomized run against a queue model.
module tb_lifo_stack_register;

  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic clk_i;
  logic reset_ni;

  lifo_stack_register_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  lifo_stack_register #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue whose back is top-of-stack, plus two sticky bits.
  logic [DW-1:0] model_q [$];
  logic          m_ovf;
  logic          m_unf;

  function automatic logic [DW-1:0] exp_top();
    return (model_q.size() == 0) ? '0 : model_q[model_q.size()-1];
  endfunction

  task automatic model_reset();
    model_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_apply(input logic push, input logic pop, input logic clr, input logic [DW-1:0] d);
    logic new_ovf;
    logic new_unf;
    new_ovf = 1'b0;
    new_unf = 1'b0;
    if (push && pop) begin
      if (model_q.size() == 0) model_q.push_back(d);
      else model_q[model_q.size()-1] = d;
    end else if (push) begin
      if (model_q.size() >= DEPTH) new_ovf = 1'b1;
      else model_q.push_back(d);
    end else if (pop) begin
      if (model_q.size() == 0) new_unf = 1'b1;
      else void'(model_q.pop_back());
    end
    m_ovf = (clr ? 1'b0 : m_ovf) | new_ovf;
    m_unf = (clr ? 1'b0 : m_unf) | new_unf;
  endtask

  // Drive one operation well after the rising edge, let the falling edge act, settle, update the model.
  task automatic step(input logic push, input logic pop, input logic clr, input logic [DW-1:0] d);
    @(posedge clk_i);
    #1;
    bus.push_ni    = push ? 1'b0 : 1'b1;
    bus.pop_ni     = pop  ? 1'b0 : 1'b1;
    bus.clr_err_ni = clr  ? 1'b0 : 1'b1;
    bus.data_i     = d;
    @(negedge clk_i);
    #1;
    model_apply(push, pop, clr, d);
    bus.push_ni    = 1'b1;
    bus.pop_ni     = 1'b1;
    bus.clr_err_ni = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk_i);
    #2;
    reset_ni = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus.count_o !== 4'd0 || bus.data_o !== 16'h0000 || bus.empty_o !== 1'b1 ||
        bus.full_o !== 1'b0 || bus.overflow_o !== 1'b0 || bus.underflow_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d data=%h empty=%b full=%b ovf=%b unf=%b, want 0 0000 1 0 0 0",
               bus.count_o, bus.data_o, bus.empty_o, bus.full_o, bus.overflow_o, bus.underflow_o);
    end
    @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    step(1'b0, 1'b0, 1'b0, 16'h1234);
    checks++;
    if (bus.count_o !== 4'd0 || bus.data_o !== 16'h0000) begin
      errors++;
      $display("FAIL idle: count=%0d data=%h, want 0 0000", bus.count_o, bus.data_o);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'h1000 + 16'(i));
      checks++;
      if (bus.data_o !== 16'h1000 + 16'(i) || bus.count_o !== 4'(i + 1)) begin
        errors++;
        $display("FAIL fill[%0d]: data=%h count=%0d, want %h %0d",
                 i, bus.data_o, bus.count_o, 16'h1000 + 16'(i), i + 1);
      end
    end
    checks++;
    if (bus.full_o !== 1'b1 || bus.empty_o !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: full=%b empty=%b, want 1 0", bus.full_o, bus.empty_o);
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, 1'b0, 16'hBEEF);
    checks++;
    if (bus.count_o !== 4'd8 || bus.data_o !== 16'h1007 || bus.overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow: count=%0d data=%h ovf=%b, want 8 1007 1",
               bus.count_o, bus.data_o, bus.overflow_o);
    end
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    checks++;
    if (bus.overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clr: ovf=%b, want 0", bus.overflow_o);
    end
    // Replacing the top of a full stack is legal and must not raise overflow.
    step(1'b1, 1'b1, 1'b0, 16'h2222);
    checks++;
    if (bus.count_o !== 4'd8 || bus.data_o !== 16'h2222 || bus.overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL replace_full: count=%0d data=%h ovf=%b, want 8 2222 0",
               bus.count_o, bus.data_o, bus.overflow_o);
    end
  endtask

  task automatic test_drain();
    logic [DW-1:0] want;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0000);
      want = (i == DEPTH - 1) ? 16'h0000 : 16'h1006 - 16'(i);
      checks++;
      if (bus.data_o !== want || bus.count_o !== 4'(DEPTH - 1 - i)) begin
        errors++;
        $display("FAIL drain[%0d]: data=%h count=%0d, want %h %0d",
                 i, bus.data_o, bus.count_o, want, DEPTH - 1 - i);
      end
    end
    checks++;
    if (bus.empty_o !== 1'b1 || bus.underflow_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: empty=%b unf=%b, want 1 0", bus.empty_o, bus.underflow_o);
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    checks++;
    if (bus.count_o !== 4'd0 || bus.underflow_o !== 1'b1 || bus.data_o !== 16'h0000) begin
      errors++;
      $display("FAIL underflow: count=%0d unf=%b data=%h, want 0 1 0000",
               bus.count_o, bus.underflow_o, bus.data_o);
    end
    step(1'b0, 1'b1, 1'b1, 16'h0000);
    checks++;
    if (bus.underflow_o !== 1'b1) begin
      errors++;
      $display("FAIL underflow_clr_race: unf=%b, want 1", bus.underflow_o);
    end
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    checks++;
    if (bus.underflow_o !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clr: unf=%b, want 0", bus.underflow_o);
    end
  endtask

  task automatic test_replace();
    step(1'b1, 1'b0, 1'b0, 16'h00AA);
    step(1'b1, 1'b0, 1'b0, 16'h00BB);
    step(1'b1, 1'b1, 1'b0, 16'h00CC);
    checks++;
    if (bus.count_o !== 4'd2 || bus.data_o !== 16'h00CC) begin
      errors++;
      $display("FAIL replace: count=%0d data=%h, want 2 00cc", bus.count_o, bus.data_o);
    end
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    checks++;
    if (bus.count_o !== 4'd1 || bus.data_o !== 16'h00AA) begin
      errors++;
      $display("FAIL replace_pop: count=%0d data=%h, want 1 00aa", bus.count_o, bus.data_o);
    end
    step(1'b0, 1'b1, 1'b0, 16'h0000);
  endtask

  task automatic test_push_pop_empty();
    step(1'b1, 1'b1, 1'b0, 16'h0055);
    checks++;
    if (bus.count_o !== 4'd1 || bus.data_o !== 16'h0055 || bus.underflow_o !== 1'b0) begin
      errors++;
      $display("FAIL pushpop_empty: count=%0d data=%h unf=%b, want 1 0055 0",
               bus.count_o, bus.data_o, bus.underflow_o);
    end
    step(1'b1, 1'b0, 1'b0, 16'h0066);
    step(1'b1, 1'b0, 1'b0, 16'h0077);
    test_reset();
  endtask

  task automatic test_random();
    logic push, pop, clr;
    logic [DW-1:0] d;
    int push_pct;
    for (int n = 0; n < 400; n++) begin
      push_pct = (n % 100 < 50) ? 75 : 25;
      push = ($urandom_range(0, 99) < push_pct);
      pop  = ($urandom_range(0, 99) < 100 - push_pct);
      clr  = ($urandom_range(0, 9) == 0);
      d    = DW'($urandom);
      step(push, pop, clr, d);
      checks++;
      if (bus.count_o !== 4'(model_q.size()) || bus.data_o !== exp_top() ||
          bus.empty_o !== (model_q.size() == 0) || bus.full_o !== (model_q.size() == DEPTH) ||
          bus.overflow_o !== m_ovf || bus.underflow_o !== m_unf) begin
        errors++;
        $display("FAIL random[%0d]: count=%0d data=%h e=%b f=%b o=%b u=%b, want %0d %h %b %b %b %b",
                 n, bus.count_o, bus.data_o, bus.empty_o, bus.full_o, bus.overflow_o, bus.underflow_o,
                 model_q.size(), exp_top(), model_q.size() == 0, model_q.size() == DEPTH, m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    reset_ni       = 1'b1;
    bus.push_ni    = 1'b1;
    bus.pop_ni     = 1'b1;
    bus.clr_err_ni = 1'b1;
    bus.data_i     = '0;
    model_reset();

    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_replace();
    test_push_pop_empty();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
